// File: rtl/tdm_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tdm_pkg
// Description : Shared constants, state encoding and helpers for tdm_demux.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package tdm_pkg;

  // Default number of multiplexed lanes
  localparam int C_LANES_DEFAULT = 4;

  // Scanner state encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } tdm_state_e;

  // Width of the lane index for a given lane count (never below 1 bit)
  function automatic int sel_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lane_counter
// Description : Wrapping lane index counter with synchronous clear and enable.
//               Flags the last lane so the parent can detect word completion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lane_counter #(
  parameter int LANES = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_count,
  output logic             o_last
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] r_count;

  // Count enabled samples; LANES is a power of two so natural overflow wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tdm_demux
// Description : Scans the select lines of an upstream combinational mux,
//               samples one lane per enabled cycle and presents the
//               reassembled word on a valid/ready output with a sticky
//               overrun flag for words dropped under backpressure.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int LANES = C_LANES_DEFAULT,
  parameter int SEL_W = sel_width(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic             din,
  output logic [SEL_W-1:0] select_lines,
  output logic [LANES-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  tdm_state_e       r_state;
  tdm_state_e       w_state_nxt;

  logic [SEL_W-1:0] w_sel;
  logic             w_last;
  logic             w_scan;
  logic             w_clr;
  logic             w_sample;
  logic             w_complete;

  logic [LANES-1:0] r_shift;
  logic [LANES-1:0] w_word;
  logic [LANES-1:0] r_out;
  logic             r_out_valid;
  logic             r_overrun;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start is a level that keeps the scanner running
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = SCAN;
      SCAN:    if (!start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sampling still happens in the cycle start drops, so a completion that
  // coincides with the abort is delivered; the lane index and partial word
  // are cleared in the same edge.
  assign w_scan     = (r_state == SCAN);
  assign w_sample   = w_scan && en;
  assign w_clr      = !w_scan || !start;
  assign w_complete = w_sample && w_last;

  lane_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_sample),
    .o_count (w_sel),
    .o_last  (w_last)
  );

  // Shift register: each enabled sample lands at the bit of its lane index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_clr) begin
      r_shift <= '0;
    end else if (w_sample) begin
      r_shift[w_sel] <= din;
    end
  end

  // Completed word bypasses the shift register for the final lane bit
  always_comb begin
    w_word            = r_shift;
    w_word[LANES-1]   = din;
  end

  // Output holding register, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_complete) begin
      if (!r_out_valid || out_ready) begin
        r_out       <= w_word;
        r_out_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign select_lines = w_sel;
  assign out          = r_out;
  assign out_valid    = r_out_valid;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
